// File: rtl/branch_seq_ctrl.sv
// PC sequencer with MIPS delay-slot redirect, link strobe and halt/fault status.
// Optional link-register logic is enabled with `define BRANCH_SEQ_LINK_EN.
//
// state | meaning
// RUN   | sequential fetch
// DSLOT | delay slot executing, redirect pending
// HALT  | stopped until reset
module branch_seq_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        condition_met,
  input  logic        is_jump,
  input  logic        link,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic        in_delay_slot,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {RUN, DSLOT, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] target_q, target_q_nxt;
  logic        fault_nxt;
  logic        take;

  assign take = condition_met | is_jump;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      pc       <= RESET_VECTOR;
      target_q <= 32'd0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      target_q <= target_q_nxt;
      fault    <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    target_q_nxt = target_q;
    fault_nxt    = fault;
    case (state)
      RUN: begin
        if (advance) begin
          if (take) begin
            // a misaligned target stops the core with pc left on the branch
            if (target[1:0] != 2'b00) begin
              fault_nxt = 1'b1;
              state_nxt = HALT;
            end else begin
              target_q_nxt = target;
              pc_nxt       = pc + 32'd4;
              state_nxt    = DSLOT;
            end
          end else begin
            pc_nxt = pc + 32'd4;
          end
        end
      end
      DSLOT: begin
        if (advance) begin
          pc_nxt    = target_q;
          state_nxt = (target_q == HALT_ADDR) ? HALT : RUN;
        end
      end
      HALT: begin
      end
      default: begin
        state_nxt = HALT;
      end
    endcase
  end

  assign in_delay_slot = (state == DSLOT);
  assign active        = (state != HALT);

`ifdef BRANCH_SEQ_LINK_EN
  // strobe is tied to retirement in RUN only, independent of the branch outcome
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      link_we   <= 1'b0;
      link_data <= 32'd0;
    end else begin
      link_we <= advance & link & (state == RUN);
      if (advance & link & (state == RUN)) begin
        link_data <= pc + 32'd8;
      end
    end
  end
`else
  logic link_unused;
  assign link_unused = link;
  assign link_we     = 1'b0;
  assign link_data   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl: directed table, corner sequences and
// randomized traffic against a behavioural PC/delay-slot model.
module tb_branch_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        advance = 1'b0;
  logic        condition_met = 1'b0;
  logic        is_jump = 1'b0;
  logic        link = 1'b0;
  logic [31:0] target = 32'd0;
  logic [31:0] pc;
  logic        in_delay_slot;
  logic        link_we;
  logic [31:0] link_data;
  logic        active;
  logic        fault;

`ifdef BRANCH_SEQ_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  localparam logic [31:0] RV = 32'hBFC00000;

  branch_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .advance(advance), .condition_met(condition_met),
    .is_jump(is_jump), .link(link), .target(target), .pc(pc),
    .in_delay_slot(in_delay_slot), .link_we(link_we), .link_data(link_data),
    .active(active), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // behavioural model: plain program-counter view of the sequencer
  bit [31:0] m_pc, m_tgt, m_ldata;
  bit        m_pending, m_halted, m_fault, m_lwe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_tgt = 0; m_ldata = 0;
    m_pending = 0; m_halted = 0; m_fault = 0; m_lwe = 0;
  endtask

  task automatic model_step(input bit adv, input bit cm, input bit j, input bit lk,
                            input bit [31:0] tgt);
    m_lwe = 0;
    if (adv && !m_halted) begin
      if (m_pending) begin
        m_pc = m_tgt;
        m_pending = 0;
        if (m_tgt == 32'd0) m_halted = 1;
      end else begin
        if (LINK_EN && lk) begin
          m_lwe = 1;
          m_ldata = m_pc + 32'd8;
        end
        if (cm || j) begin
          if (tgt % 4 != 0) begin
            m_fault = 1;
            m_halted = 1;
          end else begin
            m_tgt = tgt;
            m_pending = 1;
            m_pc = m_pc + 32'd4;
          end
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " pc"}, pc, m_pc);
    chk({tag, " in_delay_slot"}, {31'd0, in_delay_slot}, {31'd0, m_pending});
    chk({tag, " link_we"}, {31'd0, link_we}, {31'd0, m_lwe});
    chk({tag, " link_data"}, link_data, m_ldata);
    chk({tag, " active"}, {31'd0, active}, {31'd0, !m_halted});
    chk({tag, " fault"}, {31'd0, fault}, {31'd0, m_fault});
  endtask

  // called at a negedge; returns at the following negedge with outputs settled
  task automatic step(input bit adv, input bit cm, input bit j, input bit lk,
                      input logic [31:0] tgt);
    advance = adv; condition_met = cm; is_jump = j; link = lk; target = tgt;
    @(posedge clk);
    model_step(adv, cm, j, lk, tgt);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    advance = 0; condition_met = 0; is_jump = 0; link = 0; target = 0;
    #1;
    model_reset();
    cmp_model(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit adv, cm, j, lk;
    logic [31:0] tgt;
    logic [31:0] pc;
    bit ds, act, flt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 0, 0, 0, 32'h0,        32'hBFC00004, 0, 1, 0};
    vecs[1] = '{1, 0, 0, 0, 32'h0,        32'hBFC00008, 0, 1, 0};
    vecs[2] = '{1, 0, 0, 0, 32'h0,        32'hBFC0000C, 0, 1, 0};
    vecs[3] = '{0, 1, 1, 0, 32'h0,        32'hBFC0000C, 0, 1, 0};
    vecs[4] = '{1, 0, 0, 0, 32'h0,        32'hBFC00010, 0, 1, 0};
    vecs[5] = '{1, 1, 0, 0, 32'hBFC00100, 32'hBFC00014, 1, 1, 0};
    vecs[6] = '{1, 1, 0, 0, 32'hBFC00200, 32'hBFC00100, 0, 1, 0};
    vecs[7] = '{1, 0, 1, 0, 32'h0,        32'hBFC00104, 1, 1, 0};
    vecs[8] = '{1, 0, 0, 0, 32'h0,        32'h00000000, 0, 0, 0};
    vecs[9] = '{1, 1, 1, 0, 32'h40,       32'h00000000, 0, 0, 0};

    @(negedge clk);
    do_reset("reset");
    chk("reset pc const", pc, RV);
    chk("reset active const", {31'd0, active}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].adv, vecs[i].cm, vecs[i].j, vecs[i].lk, vecs[i].tgt);
      chk($sformatf("vec%0d pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d in_delay_slot", i), {31'd0, in_delay_slot}, {31'd0, vecs[i].ds});
      chk($sformatf("vec%0d active", i), {31'd0, active}, {31'd0, vecs[i].act});
      chk($sformatf("vec%0d fault", i), {31'd0, fault}, {31'd0, vecs[i].flt});
    end

    // link strobe on a not-taken BGEZAL, then held data, then no strobe from a delay slot
    do_reset("reset2");
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("bgezal pc", pc, 32'hBFC00024);
    chk("bgezal link_we", {31'd0, link_we}, {31'd0, LINK_EN});
    chk("bgezal link_data", link_data, LINK_EN ? 32'hBFC00028 : 32'h0);
    cmp_model("bgezal");
    step(0, 0, 0, 1, 0);
    chk("link_we one cycle", {31'd0, link_we}, 32'd0);
    chk("link_data held", link_data, LINK_EN ? 32'hBFC00028 : 32'h0);
    step(1, 1, 0, 0, 32'hBFC00200);
    step(1, 0, 0, 1, 0);
    chk("dslot link pc", pc, 32'hBFC00200);
    chk("dslot link no strobe", {31'd0, link_we}, 32'd0);
    cmp_model("dslot link");

    // misaligned target faults and holds pc on the branch
    step(1, 1, 0, 0, 32'hBFC00102);
    chk("fault flag", {31'd0, fault}, 32'd1);
    chk("fault active", {31'd0, active}, 32'd0);
    chk("fault pc held", pc, 32'hBFC00200);
    step(1, 1, 0, 0, 32'hBFC00300);
    cmp_model("after fault");

    // wrap through zero does not halt
    do_reset("reset3");
    step(1, 0, 1, 0, 32'hFFFFFFF8);
    step(1, 0, 0, 0, 0);
    chk("wrap target", pc, 32'hFFFFFFF8);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("wrap pc zero", pc, 32'h0);
    chk("wrap still active", {31'd0, active}, 32'd1);
    step(1, 0, 0, 0, 0);
    cmp_model("wrap");

    // reset in the middle of a delay slot drops the redirect
    step(1, 1, 0, 0, 32'hBFC00100);
    chk("pre-reset dslot", {31'd0, in_delay_slot}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid-dslot reset pc", pc, RV);
    chk("mid-dslot reset ds", {31'd0, in_delay_slot}, 32'd0);
    do_reset("reset4");
    step(1, 0, 0, 0, 0);
    chk("no stale redirect", pc, 32'hBFC00004);
    cmp_model("post reset");

    // randomized traffic against the model
    do_reset("reset5");
    for (int n = 0; n < 3000; n++) begin
      bit adv, cm, j, lk;
      logic [31:0] tgt;
      int sel;
      adv = ($urandom_range(0, 3) != 0);
      cm  = ($urandom_range(0, 6) == 0);
      j   = ($urandom_range(0, 9) == 0);
      lk  = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 19);
      if (sel == 0)      tgt = 32'h0;
      else if (sel == 1) tgt = $urandom | 32'h1;
      else if (sel == 2) tgt = 32'hFFFFFFFC;
      else               tgt = $urandom & 32'hFFFFFFFC;
      if ((m_halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0)
        do_reset("rand reset");
      step(adv, cm, j, lk, tgt);
      cmp_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
